// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// NOP_INSTR is the word presented to decode whenever no real instruction is available.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {IR, PC, valid} holding register.
// It catches a fetched word while decode is stalled and the FD slot is already occupied.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] ir,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        // flush wins: a redirect must never let a stale word survive
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            ir_d    = ir_in;
            pc_d    = pc_in;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ir_q    <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign ir    = ir_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the I-cache, and feeds FD_IR/FD_PC to decode.
// Decode stalls are absorbed by a one-entry skid buffer; downstream redirects flush the stage and refetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    output logic              I_MEM_REQ,
    output logic [ADDR_W-1:0] I_MEM_ADDR,
    input  logic              I_MEM_ACK,
    input  logic [31:0]       I_MEM_DI,
    input  logic              STALL,
    input  logic              REDIRECT,
    input  logic [31:0]       REDIRECT_PC,
    output logic [31:0]       FD_IR,
    output logic [31:0]       FD_PC,
    output logic              FD_VALID,
    output fetch_state_e      DBG_STATE
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         req_en_q;
    logic         fd_valid_q, fd_valid_d;
    logic [31:0]  fd_ir_q, fd_ir_d;
    logic [31:0]  fd_pc_q, fd_pc_d;

    logic         skid_valid;
    logic [31:0]  skid_ir, skid_pc;
    logic         skid_load, skid_unload, skid_flush;

    logic         mem_req;
    logic         ack_v;
    logic [31:0]  redirect_pc_a;

    // req_en_q is low only during reset, so a late ACK arriving in reset is ignored
    assign mem_req       = req_en_q & ~skid_valid;
    assign ack_v         = mem_req & I_MEM_ACK;
    assign redirect_pc_a = align_pc(REDIRECT_PC);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_pc_d   = pend_pc_q;
        fd_valid_d  = fd_valid_q;
        fd_ir_d     = fd_ir_q;
        fd_pc_d     = fd_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (REDIRECT) begin
            fd_valid_d = 1'b0;
            skid_flush = 1'b0 | 1'b1;
            pend_pc_d  = redirect_pc_a;
            // An un-acked request cannot be withdrawn, so wait it out in S_DROP.
            // An ACK in the same cycle completes any pending drop, so fetch starts at the new target.
            if (mem_req && !I_MEM_ACK) begin
                state_d = S_DROP;
            end else begin
                state_d    = S_FETCH;
                fetch_pc_d = redirect_pc_a;
            end
        end else if (state_q == S_DROP) begin
            if (ack_v) begin
                state_d    = S_FETCH;
                fetch_pc_d = pend_pc_q;
            end
        end else if (skid_valid) begin
            if (!fd_valid_q || !STALL) begin
                fd_valid_d  = 1'b1;
                fd_ir_d     = skid_ir;
                fd_pc_d     = skid_pc;
                skid_unload = 1'b1;
            end
        end else if (ack_v) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (!fd_valid_q || !STALL) begin
                fd_valid_d = 1'b1;
                fd_ir_d    = I_MEM_DI;
                fd_pc_d    = fetch_pc_q;
            end else begin
                skid_load = 1'b1;
            end
        end else if (fd_valid_q && !STALL) begin
            fd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            req_en_q   <= 1'b0;
            fd_valid_q <= 1'b0;
            fd_ir_q    <= NOP_INSTR;
            fd_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            req_en_q   <= 1'b1;
            fd_valid_q <= fd_valid_d;
            fd_ir_q    <= fd_ir_d;
            fd_pc_q    <= fd_pc_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk    (CLK),
        .rst_n  (RSTn),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .ir_in  (I_MEM_DI),
        .pc_in  (fetch_pc_q),
        .valid  (skid_valid),
        .ir     (skid_ir),
        .pc     (skid_pc)
    );

    assign I_MEM_REQ  = mem_req;
    assign I_MEM_ADDR = fetch_pc_q[ADDR_W-1:0];
    assign FD_VALID   = fd_valid_q;
    assign FD_IR      = fd_valid_q ? fd_ir_q : NOP_INSTR;
    assign FD_PC      = fd_pc_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic.
// All outputs are compared every cycle against a FIFO-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] T_NOP      = 32'h0000_0013;
  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        i_mem_req;
  logic [11:0] i_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_di;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fd_ir;
  logic [31:0] fd_pc;
  logic        fd_valid;
  fetch_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(.RESET_PC(T_RESET_PC), .ADDR_W(12)) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .I_MEM_REQ  (i_mem_req),
    .I_MEM_ADDR (i_mem_addr),
    .I_MEM_ACK  (i_mem_ack),
    .I_MEM_DI   (i_mem_di),
    .STALL      (stall),
    .REDIRECT   (redirect),
    .REDIRECT_PC(redirect_pc),
    .FD_IR      (fd_ir),
    .FD_PC      (fd_pc),
    .FD_VALID   (fd_valid),
    .DBG_STATE  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instructions visible to decode form a queue of at most two entries.
  // Head is FD and the second entry is the word held back while decode stalls.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_fd_pc;
  bit          m_drop;
  bit          m_req_en;

  function automatic bit m_req();
    return m_req_en && (m_q.size() < 2);
  endfunction

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return 32'hC0DE_0000 | {16'd0, pc[15:0]};
  endfunction

  task automatic model_step(input bit rst, input bit stall_i, input bit redir_i,
                            input logic [31:0] rpc, input bit ack_i, input logic [31:0] di_i);
    bit req;
    bit ack_v;
    logic [31:0] tgt;
    entry_t e;
    req   = m_req();
    ack_v = req && ack_i;
    tgt   = rpc & 32'hFFFF_FFFC;
    if (!rst) begin
      m_q.delete();
      m_pc     = T_RESET_PC;
      m_pend   = T_RESET_PC;
      m_drop   = 1'b0;
      m_req_en = 1'b0;
      m_fd_pc  = 32'd0;
    end else begin
      if (redir_i) begin
        m_q.delete();
        if (req && !ack_i) begin
          m_drop = 1'b1;
          m_pend = tgt;
        end else begin
          m_drop = 1'b0;
          m_pc   = tgt;
        end
      end else if (m_drop) begin
        if (ack_v) begin
          m_drop = 1'b0;
          m_pc   = m_pend;
        end
      end else begin
        if (m_q.size() > 0 && !stall_i) void'(m_q.pop_front());
        if (ack_v) begin
          e.ir = di_i;
          e.pc = m_pc;
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
      m_req_en = 1'b1;
      if (m_q.size() > 0) m_fd_pc = m_q[0].pc;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_ir;
    exp_ir = (m_q.size() > 0) ? m_q[0].ir : T_NOP;
    check("i_mem_req", {31'd0, i_mem_req}, {31'd0, m_req()});
    if (m_req()) check("i_mem_addr", {20'd0, i_mem_addr}, {20'd0, m_pc[11:0]});
    check("fd_valid", {31'd0, fd_valid}, {31'd0, (m_q.size() > 0)});
    check("fd_ir", fd_ir, exp_ir);
    check("fd_pc", fd_pc, m_fd_pc);
    check("dbg_state", {31'd0, dbg_state}, {31'd0, m_drop});
  endtask

  // driver
  task automatic cycle(input bit rst, input bit stall_i, input bit redir_i,
                       input logic [31:0] rpc, input bit ack_i, input logic [31:0] di_i);
    rst_n       = rst;
    stall       = stall_i;
    redirect    = redir_i;
    redirect_pc = rpc;
    i_mem_ack   = ack_i;
    i_mem_di    = di_i;
    model_step(rst, stall_i, redir_i, rpc, ack_i, di_i);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic hit(input logic [31:0] pc);
    cycle(1, 0, 0, 32'd0, 1, dat(pc));
  endtask

  task automatic idle();
    cycle(1, 0, 0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    i_mem_ack = 1'b0; i_mem_di = 32'd0;
    m_q.delete(); m_pc = T_RESET_PC; m_pend = T_RESET_PC; m_fd_pc = 32'd0;
    m_drop = 1'b0; m_req_en = 1'b0;
    @(posedge clk);
    #1;

    // reset state, with an ACK during reset that must be ignored
    cycle(0, 0, 0, 32'd0, 0, 32'd0);
    cycle(0, 0, 0, 32'd0, 1, dat(32'h0));
    check("rst_fd_valid", {31'd0, fd_valid}, 32'd0);
    check("rst_fd_ir", fd_ir, 32'h0000_0013);
    check("rst_fd_pc", fd_pc, 32'd0);
    check("rst_req", {31'd0, i_mem_req}, 32'd0);
    idle();
    check("first_req", {31'd0, i_mem_req}, 32'd1);
    check("first_addr", {20'd0, i_mem_addr}, 32'h0);

    // back-to-back hits
    hit(32'h0);
    check("hit0_pc", fd_pc, 32'h0);
    check("hit0_ir", fd_ir, 32'hC0DE_0000);
    check("hit0_addr", {20'd0, i_mem_addr}, 32'h4);
    hit(32'h4);
    hit(32'h8);
    check("hit8_pc", fd_pc, 32'h8);
    check("hit8_addr", {20'd0, i_mem_addr}, 32'hC);
    hit(32'hC);

    // three-cycle miss at 0x10
    idle();
    check("miss_valid", {31'd0, fd_valid}, 32'd0);
    check("miss_nop", fd_ir, 32'h0000_0013);
    idle();
    idle();
    check("miss_addr", {20'd0, i_mem_addr}, 32'h10);
    hit(32'h10);
    check("miss_done_pc", fd_pc, 32'h10);
    for (int a = 32'h14; a <= 32'h20; a += 4) hit(a);
    check("pre_stall_pc", fd_pc, 32'h20);

    // stall: one word into the skid, then requests stop
    cycle(1, 1, 0, 32'd0, 1, dat(32'h24));
    check("skid_full_req", {31'd0, i_mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'd0, 1, 32'h0BAD_0BAD);
    check("stall_hold_pc", fd_pc, 32'h20);
    check("stall_hold_ir", fd_ir, 32'hC0DE_0020);
    idle();
    check("unskid_pc", fd_pc, 32'h24);
    check("unskid_addr", {20'd0, i_mem_addr}, 32'h28);
    hit(32'h28);
    check("after_skid_pc", fd_pc, 32'h28);
    hit(32'h2C);

    // redirect coinciding with an ACK
    cycle(1, 0, 1, 32'h100, 1, dat(32'h30));
    check("redir_valid", {31'd0, fd_valid}, 32'd0);
    check("redir_addr", {20'd0, i_mem_addr}, 32'h100);
    hit(32'h100);
    check("redir_fd_pc", fd_pc, 32'h100);

    // redirect during a miss, then a second redirect while draining
    cycle(1, 0, 1, 32'h40, 1, dat(32'h104));
    idle();
    cycle(1, 0, 1, 32'h200, 0, 32'd0);
    check("drop_state", {31'd0, dbg_state}, 32'd1);
    check("drop_addr", {20'd0, i_mem_addr}, 32'h40);
    cycle(1, 0, 1, 32'h303, 0, 32'd0);
    hit(32'h40);
    check("drop_discard", {31'd0, fd_valid}, 32'd0);
    check("drop_next_addr", {20'd0, i_mem_addr}, 32'h300);
    hit(32'h300);
    check("drop_fd_pc", fd_pc, 32'h300);

    // PC wrap at the top of the address space
    cycle(1, 0, 1, 32'hFFFF_FFFC, 1, dat(32'h304));
    hit(32'hFFFF_FFFC);
    check("wrap_fd_pc", fd_pc, 32'hFFFF_FFFC);
    check("wrap_addr", {20'd0, i_mem_addr}, 32'h0);

    // reset in the middle of a miss, late ACK during reset
    idle();
    cycle(0, 0, 0, 32'd0, 1, 32'h1111_1111);
    check("midrst_req", {31'd0, i_mem_req}, 32'd0);
    check("midrst_valid", {31'd0, fd_valid}, 32'd0);
    cycle(0, 0, 0, 32'd0, 1, 32'h2222_2222);
    idle();
    check("postrst_addr", {20'd0, i_mem_addr}, 32'h0);
    check("postrst_valid", {31'd0, fd_valid}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit r_rst, r_stall, r_redir, r_ack;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 199) != 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      r_ack   = ($urandom_range(0, 2) != 0);
      cycle(r_rst, r_stall, r_redir, r_pc, r_ack, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
